// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control, Execute-stage forwarding selects,
// multi-cycle multiply/divide hold FSM and stall/flush performance counters
// for the 5-stage core.
module hazard_unit #(
  parameter int RW     = 5,
  parameter int MD_LAT = 4,
  parameter int CW     = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [RW-1:0] RS1_D,
  input  logic [RW-1:0] RS2_D,
  input  logic [RW-1:0] RS1_E,
  input  logic [RW-1:0] RS2_E,
  input  logic [RW-1:0] RD_E,
  input  logic [RW-1:0] RD_M,
  input  logic [RW-1:0] RD_W,
  input  logic          REGWR_E,
  input  logic          REGWR_M,
  input  logic          REGWR_W,
  input  logic          MEMRD_E,
  input  logic          PCSRC_E,
  input  logic          MDSTART_E,
  output logic          STALL_F,
  output logic          STALL_D,
  output logic          STALL_E,
  output logic          FLUSH_D,
  output logic          FLUSH_E,
  output logic          FLUSH_M,
  output logic [1:0]    FWD_A_E,
  output logic [1:0]    FWD_B_E,
  output logic          MD_BUSY,
  output logic [CW-1:0] STALL_CYC,
  output logic [CW-1:0] FLUSH_CYC
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // BUSY is entered after the first stall cycle, so MD_LAT-2 further stall
  // cycles remain before the release cycle.
  localparam logic [3:0]    MD_INIT = 4'(MD_LAT - 2);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;
  logic       mds;

  // Memory-stage result has priority over Writeback; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] rs,
    input logic [RW-1:0] rd_m,
    input logic          wr_m,
    input logic [RW-1:0] rd_w,
    input logic          wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard conditions: load-use on a Decode source, and multi-cycle hold
  // (start cycle plus every BUSY cycle except the release cycle).
  always_comb begin
    lu  = MEMRD_E && REGWR_E && (RD_E != '0) &&
          ((RD_E == RS1_D) || (RD_E == RS2_D));
    mds = ((state_q == IDLE) && MDSTART_E) ||
          ((state_q == BUSY) && (cnt_q != 4'd0));
  end

  // Prioritised stall/flush generation, forced quiet while in reset.
  always_comb begin
    STALL_F = 1'b0;
    STALL_D = 1'b0;
    STALL_E = 1'b0;
    FLUSH_D = 1'b0;
    FLUSH_E = 1'b0;
    FLUSH_M = 1'b0;
    if (!RST) begin
      if (mds) begin
        STALL_F = 1'b1;
        STALL_D = 1'b1;
        STALL_E = 1'b1;
        FLUSH_M = 1'b1;
      end else if (PCSRC_E) begin
        FLUSH_D = 1'b1;
        FLUSH_E = 1'b1;
      end else if (lu) begin
        STALL_F = 1'b1;
        STALL_D = 1'b1;
        FLUSH_E = 1'b1;
      end
    end
  end

  // Execute-stage operand forwarding selects and busy flag.
  always_comb begin
    FWD_A_E = 2'b00;
    FWD_B_E = 2'b00;
    MD_BUSY = 1'b0;
    if (!RST) begin
      FWD_A_E = fwd_sel(RS1_E, RD_M, REGWR_M, RD_W, REGWR_W);
      FWD_B_E = fwd_sel(RS2_E, RD_M, REGWR_M, RD_W, REGWR_W);
      MD_BUSY = (state_q == BUSY);
    end
  end

  // Multi-cycle FSM next state; MDSTART_E is ignored in the release cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MDSTART_E) begin
          state_d = BUSY;
          cnt_d   = MD_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state register; reset aborts any op in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Performance counters of stalled and flushed cycles, wrapping naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CYC <= '0;
      FLUSH_CYC <= '0;
    end else begin
      if (STALL_F) begin
        STALL_CYC <= STALL_CYC + ONE;
      end
      if (FLUSH_E) begin
        FLUSH_CYC <= FLUSH_CYC + ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scenario-driven scoreboard bench for hazard_unit.
// Expected output vectors are queued as each cycle's stimulus is applied and
// popped for comparison mid-cycle; counter expectations are tracked alongside.
module tb_hazard_unit;

  logic        CLK;
  logic        RST;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic        REGWR_E, REGWR_M, REGWR_W, MEMRD_E, PCSRC_E, MDSTART_E;
  logic        STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M;
  logic [1:0]  FWD_A_E, FWD_B_E;
  logic        MD_BUSY;
  logic [31:0] STALL_CYC, FLUSH_CYC;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwr_e, regwr_m, regwr_w, memrd_e, pcsrc_e, mdstart_e;
  } stim_t;

  // Output vector layout:
  // [10]STALL_F [9]STALL_D [8]STALL_E [7]FLUSH_D [6]FLUSH_E [5]FLUSH_M
  // [4:3]FWD_A_E [2:1]FWD_B_E [0]MD_BUSY
  logic [10:0] obs;
  logic [10:0] exp_q[$];
  logic [31:0] exp_sc;
  logic [31:0] exp_fc;
  int          tests;
  int          fails;

  assign obs = {STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M,
                FWD_A_E, FWD_B_E, MD_BUSY};

  hazard_unit #(.RW(5), .MD_LAT(4), .CW(32)) dut (
    .CLK(CLK), .RST(RST),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .REGWR_E(REGWR_E), .REGWR_M(REGWR_M), .REGWR_W(REGWR_W),
    .MEMRD_E(MEMRD_E), .PCSRC_E(PCSRC_E), .MDSTART_E(MDSTART_E),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E),
    .FLUSH_D(FLUSH_D), .FLUSH_E(FLUSH_E), .FLUSH_M(FLUSH_M),
    .FWD_A_E(FWD_A_E), .FWD_B_E(FWD_B_E), .MD_BUSY(MD_BUSY),
    .STALL_CYC(STALL_CYC), .FLUSH_CYC(FLUSH_CYC)
  );

  // Free-running clock, first rising edge at t=5.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t lu_stim();
    stim_t s;
    s = '0;
    s.memrd_e = 1'b1;
    s.regwr_e = 1'b1;
    s.rd_e    = 5'd5;
    s.rs2_d   = 5'd5;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    RST       = s.rst;
    RS1_D     = s.rs1_d;
    RS2_D     = s.rs2_d;
    RS1_E     = s.rs1_e;
    RS2_E     = s.rs2_e;
    RD_E      = s.rd_e;
    RD_M      = s.rd_m;
    RD_W      = s.rd_w;
    REGWR_E   = s.regwr_e;
    REGWR_M   = s.regwr_m;
    REGWR_W   = s.regwr_w;
    MEMRD_E   = s.memrd_e;
    PCSRC_E   = s.pcsrc_e;
    MDSTART_E = s.mdstart_e;
  endtask

  task automatic test_reset();
    stim_t       s[3];
    logic [10:0] ev[3];
    logic [10:0] e;
    s[0] = idle();
    s[0].rst = 1'b1;
    s[0].rs1_e = 5'd3;
    s[0].rd_m = 5'd3;
    s[0].regwr_m = 1'b1;
    s[0].mdstart_e = 1'b1;
    s[0].pcsrc_e = 1'b1;
    s[1] = s[0];
    s[2] = idle();
    ev[0] = 11'b0; ev[1] = 11'b0; ev[2] = 11'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL reset[%0d] outputs got=%b want=%b", i, obs, e);
      end
      if (i > 0) begin
        tests++;
        if (STALL_CYC !== exp_sc || FLUSH_CYC !== exp_fc) begin
          fails++;
          $display("[TB] FAIL reset[%0d] counters got=%0d/%0d want=%0d/%0d",
                   i, STALL_CYC, FLUSH_CYC, exp_sc, exp_fc);
        end
      end
      if (s[i].rst) begin exp_sc = 0; exp_fc = 0; end
      else begin exp_sc += 32'(e[10]); exp_fc += 32'(e[6]); end
    end
  endtask

  task automatic test_forwarding();
    stim_t       s[4];
    logic [10:0] ev[4];
    logic [10:0] e;
    s[0] = idle();
    s[0].rs1_e = 5'd3; s[0].rs2_e = 5'd3;
    s[0].rd_m = 5'd3;  s[0].regwr_m = 1'b1;
    s[0].rd_w = 5'd3;  s[0].regwr_w = 1'b1;
    ev[0] = 11'b000_000_10_10_0;
    s[1] = s[0];
    s[1].regwr_m = 1'b0;
    ev[1] = 11'b000_000_01_01_0;
    s[2] = s[0];
    s[2].rs1_e = 5'd0; s[2].rs2_e = 5'd0;
    s[2].rd_m = 5'd0;  s[2].rd_w = 5'd0;
    ev[2] = 11'b000_000_00_00_0;
    s[3] = idle();
    s[3].rs1_e = 5'd3; s[3].rs2_e = 5'd7;
    s[3].rd_m = 5'd3;  s[3].regwr_m = 1'b1;
    s[3].rd_w = 5'd7;  s[3].regwr_w = 1'b1;
    ev[3] = 11'b000_000_10_01_0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL fwd[%0d] outputs got=%b want=%b", i, obs, e);
      end
      exp_sc += 32'(e[10]); exp_fc += 32'(e[6]);
    end
  endtask

  task automatic test_load_use();
    stim_t       s[4];
    logic [10:0] ev[4];
    logic [10:0] e;
    s[0] = lu_stim();
    ev[0] = 11'b110_010_00_00_0;
    s[1] = idle();
    ev[1] = 11'b0;
    s[2] = lu_stim();
    s[2].rd_e = 5'd0; s[2].rs2_d = 5'd0;
    ev[2] = 11'b0;
    s[3] = lu_stim();
    s[3].memrd_e = 1'b0;
    ev[3] = 11'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL loaduse[%0d] outputs got=%b want=%b", i, obs, e);
      end
      tests++;
      if (STALL_CYC !== exp_sc || FLUSH_CYC !== exp_fc) begin
        fails++;
        $display("[TB] FAIL loaduse[%0d] counters got=%0d/%0d want=%0d/%0d",
                 i, STALL_CYC, FLUSH_CYC, exp_sc, exp_fc);
      end
      exp_sc += 32'(e[10]); exp_fc += 32'(e[6]);
    end
  endtask

  task automatic test_branch_over_lu();
    stim_t       s[2];
    logic [10:0] ev[2];
    logic [10:0] e;
    s[0] = lu_stim();
    s[0].pcsrc_e = 1'b1;
    ev[0] = 11'b000_110_00_00_0;
    s[1] = idle();
    ev[1] = 11'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL branch[%0d] outputs got=%b want=%b", i, obs, e);
      end
      tests++;
      if (STALL_CYC !== exp_sc || FLUSH_CYC !== exp_fc) begin
        fails++;
        $display("[TB] FAIL branch[%0d] counters got=%0d/%0d want=%0d/%0d",
                 i, STALL_CYC, FLUSH_CYC, exp_sc, exp_fc);
      end
      exp_sc += 32'(e[10]); exp_fc += 32'(e[6]);
    end
  endtask

  task automatic test_multicycle();
    stim_t       s[6];
    logic [10:0] ev[6];
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      s[i] = idle();
      s[i].mdstart_e = 1'b1;
    end
    // Lower-priority hazards during the hold must not leak through.
    s[1] = lu_stim();
    s[1].mdstart_e = 1'b1;
    s[2].pcsrc_e = 1'b1;
    s[4] = idle();
    s[5] = idle();
    ev[0] = 11'b111_001_00_00_0;
    ev[1] = 11'b111_001_00_00_1;
    ev[2] = 11'b111_001_00_00_1;
    ev[3] = 11'b000_000_00_00_1;
    ev[4] = 11'b0;
    ev[5] = 11'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL mdop[%0d] outputs got=%b want=%b", i, obs, e);
      end
      tests++;
      if (STALL_CYC !== exp_sc || FLUSH_CYC !== exp_fc) begin
        fails++;
        $display("[TB] FAIL mdop[%0d] counters got=%0d/%0d want=%0d/%0d",
                 i, STALL_CYC, FLUSH_CYC, exp_sc, exp_fc);
      end
      exp_sc += 32'(e[10]); exp_fc += 32'(e[6]);
    end
  endtask

  task automatic test_back_to_back();
    stim_t       s[9];
    logic [10:0] ev[9];
    logic [10:0] e;
    for (int i = 0; i < 8; i++) begin
      s[i] = idle();
      s[i].mdstart_e = 1'b1;
    end
    s[8] = idle();
    ev[0] = 11'b111_001_00_00_0;
    ev[1] = 11'b111_001_00_00_1;
    ev[2] = 11'b111_001_00_00_1;
    ev[3] = 11'b000_000_00_00_1;
    ev[4] = 11'b111_001_00_00_0;
    ev[5] = 11'b111_001_00_00_1;
    ev[6] = 11'b111_001_00_00_1;
    ev[7] = 11'b000_000_00_00_1;
    ev[8] = 11'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL b2b[%0d] outputs got=%b want=%b", i, obs, e);
      end
      tests++;
      if (STALL_CYC !== exp_sc || FLUSH_CYC !== exp_fc) begin
        fails++;
        $display("[TB] FAIL b2b[%0d] counters got=%0d/%0d want=%0d/%0d",
                 i, STALL_CYC, FLUSH_CYC, exp_sc, exp_fc);
      end
      exp_sc += 32'(e[10]); exp_fc += 32'(e[6]);
    end
  endtask

  task automatic test_abort();
    stim_t       s[8];
    logic [10:0] ev[8];
    logic [10:0] e;
    for (int i = 0; i < 8; i++) begin
      s[i] = idle();
    end
    s[0].mdstart_e = 1'b1;
    s[1].mdstart_e = 1'b1;
    s[1].rst = 1'b1;
    s[3].mdstart_e = 1'b1;
    s[4].mdstart_e = 1'b1;
    s[5].mdstart_e = 1'b1;
    s[6].mdstart_e = 1'b1;
    ev[0] = 11'b111_001_00_00_0;
    ev[1] = 11'b0;
    ev[2] = 11'b0;
    ev[3] = 11'b111_001_00_00_0;
    ev[4] = 11'b111_001_00_00_1;
    ev[5] = 11'b111_001_00_00_1;
    ev[6] = 11'b000_000_00_00_1;
    ev[7] = 11'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      applyStimulus(s[i]);
      exp_q.push_back(ev[i]);
      #3;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("[TB] FAIL abort[%0d] outputs got=%b want=%b", i, obs, e);
      end
      tests++;
      if (STALL_CYC !== exp_sc || FLUSH_CYC !== exp_fc) begin
        fails++;
        $display("[TB] FAIL abort[%0d] counters got=%0d/%0d want=%0d/%0d",
                 i, STALL_CYC, FLUSH_CYC, exp_sc, exp_fc);
      end
      if (s[i].rst) begin exp_sc = 0; exp_fc = 0; end
      else begin exp_sc += 32'(e[10]); exp_fc += 32'(e[6]); end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    tests  = 0;
    fails  = 0;
    exp_sc = 0;
    exp_fc = 0;
    applyStimulus(idle());
    RST = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_lu();
    test_multicycle();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
